// File: rtl/lsq_unit.sv
// lsq_unit: circular load/store queue tracking in-flight memory ops from dispatch to commit,
// absorbing address/data updates and miss fills, and draining committed stores to the cache.
module lsq_unit #(
  parameter int LSQ_SIZE = 16,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W = 32,
  parameter int PTR_W = $clog2(LSQ_SIZE) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic alloc_valid,
  input  logic alloc_category,
  input  logic [TAG_W-1:0] alloc_tag,
  output logic alloc_ready,
  input  logic [PTR_W-1:0] upd_pointer,
  input  logic [ADDR_W-1:0] upd_address,
  input  logic [DATA_W-1:0] upd_value,
  input  logic upd_ready,
  input  logic fill_valid,
  input  logic [PTR_W-2:0] fill_index,
  input  logic [DATA_W-1:0] fill_data,
  input  logic commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  output logic commit_error,
  input  logic flush,
  output logic mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic mem_wr_ack,
  output logic [LSQ_SIZE-1:0][TAG_W+ADDR_W+DATA_W+34:0] lsq_out,
  output logic [PTR_W-2:0] lsq_tail,
  output logic [PTR_W-1:0] lsq_count
);
  localparam int IW = PTR_W - 1;
  typedef struct packed {
    logic valid;
    logic category;
    logic [TAG_W-1:0] tag;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] value;
    logic ready;
    logic [31:0] color;
  } entry_t;
  typedef enum logic {IDLE, STORE_WAIT} state_t;
  entry_t q [LSQ_SIZE];
  logic [IW-1:0] head, tail;
  logic [PTR_W-1:0] count;
  logic [31:0] color_ctr;
  state_t state, state_n;
  logic hit, do_alloc, do_free, latch, err_n;
  assign alloc_ready = count < PTR_W'(LSQ_SIZE);
  assign mem_wr_req = state == STORE_WAIT;
  assign lsq_tail = tail;
  assign lsq_count = count;
  for (genvar g = 0; g < LSQ_SIZE; g++) begin : g_out
    assign lsq_out[g] = q[g];
  end
  always_comb begin
    state_n = state;
    do_free = 1'b0;
    latch = 1'b0;
    err_n = 1'b0;
    hit = q[head].valid && q[head].tag == commit_tag;
    do_alloc = alloc_valid && alloc_ready && !flush;
    if (state == IDLE) begin
      if (commit_valid && !flush) begin
        err_n = !hit;
        do_free = hit && !q[head].category;
        latch = hit && q[head].category;
        state_n = latch ? STORE_WAIT : IDLE;
      end
    end else if (mem_wr_ack) begin
      do_free = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LSQ_SIZE; i++) q[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      color_ctr <= '0;
      commit_error <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      commit_error <= err_n;
      if (latch) begin
        mem_wr_addr <= q[head].address;
        mem_wr_data <= q[head].value;
      end
      // later writes win: fill over update, allocation over both, invalidation last
      for (int i = 0; i < LSQ_SIZE; i++) begin
        if (upd_pointer == PTR_W'(i + 1) && q[i].valid) begin
          q[i].address <= upd_address;
          q[i].value <= upd_value;
          q[i].ready <= upd_ready;
        end
        if (fill_valid && fill_index == IW'(i)) begin
          q[i].value <= fill_data;
          q[i].ready <= 1'b1;
        end
        if (do_alloc && tail == IW'(i))
          q[i] <= '{valid: 1'b1, category: alloc_category, tag: alloc_tag, address: '0,
                    value: '0, ready: 1'b0, color: color_ctr};
        if (flush && !(state == STORE_WAIT && head == IW'(i))) q[i].valid <= 1'b0;
        if (do_free && head == IW'(i)) q[i].valid <= 1'b0;
      end
      if (do_alloc) color_ctr <= color_ctr + 1'b1;
      if (do_free) head <= head + 1'b1;
      if (flush) begin
        tail <= state == STORE_WAIT ? head + 1'b1 : head;
        count <= PTR_W'(state == STORE_WAIT && !mem_wr_ack);
      end else begin
        if (do_alloc) tail <= tail + 1'b1;
        count <= count + PTR_W'(do_alloc) - PTR_W'(do_free);
      end
    end
  end
endmodule

// File: tb/tb_lsq_unit.sv
// tb_lsq_unit: directed and randomized checks of lsq_unit against a queue-level reference model.
module tb_lsq_unit;
  localparam int N = 16, AW = 64, DW = 64, TW = 32, PW = 5, EW = TW + AW + DW + 35;
  localparam int VB = EW - 1, CB = EW - 2, TH = EW - 3, TL = TH - TW + 1;
  localparam int AH = TL - 1, AL = AH - AW + 1, DH = AL - 1, DL = DH - DW + 1, RB = DL - 1;
  logic clk = 1'b0, reset = 1'b0;
  logic alloc_valid, alloc_category, alloc_ready;
  logic [TW-1:0] alloc_tag, commit_tag;
  logic [PW-1:0] upd_pointer, lsq_count;
  logic [AW-1:0] upd_address, mem_wr_addr;
  logic [DW-1:0] upd_value, fill_data, mem_wr_data;
  logic upd_ready, fill_valid, commit_valid, commit_error, flush, mem_wr_req, mem_wr_ack;
  logic [PW-2:0] fill_index, lsq_tail;
  logic [N-1:0][EW-1:0] lsq_out;
  int passed = 0, total = 0;
  bit chk_en = 1'b0;
  bit m_v[N], m_cat[N], m_rdy[N];
  logic [TW-1:0] m_tag[N];
  logic [AW-1:0] m_addr[N];
  logic [DW-1:0] m_val[N];
  logic [31:0] m_col[N];
  logic [31:0] m_color;
  int m_head, m_tail, m_cnt;
  bit m_wait, m_err;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  lsq_unit dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_category(alloc_category), .alloc_tag(alloc_tag),
    .alloc_ready(alloc_ready),
    .upd_pointer(upd_pointer), .upd_address(upd_address), .upd_value(upd_value),
    .upd_ready(upd_ready),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_data(fill_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_error(commit_error),
    .flush(flush),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack),
    .lsq_out(lsq_out), .lsq_tail(lsq_tail), .lsq_count(lsq_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_cat[i] = 0; m_rdy[i] = 0;
      m_tag[i] = '0; m_addr[i] = '0; m_val[i] = '0; m_col[i] = '0;
    end
    m_color = '0; m_head = 0; m_tail = 0; m_cnt = 0;
    m_wait = 0; m_err = 0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic model_step();
    int h, p;
    bit acc, freed, go, err;
    h = m_head; freed = 0; go = 0; err = 0;
    acc = alloc_valid && m_cnt < N && !flush;
    if (!m_wait) begin
      if (commit_valid && !flush) begin
        if (!(m_v[h] && m_tag[h] == commit_tag)) err = 1;
        else if (m_cat[h]) begin
          go = 1; m_waddr = m_addr[h]; m_wdata = m_val[h];
        end else freed = 1;
      end
    end else freed = mem_wr_ack;
    p = int'(upd_pointer);
    if (p >= 1 && p <= N && m_v[p-1]) begin
      m_addr[p-1] = upd_address; m_val[p-1] = upd_value; m_rdy[p-1] = upd_ready;
    end
    if (fill_valid) begin
      m_val[fill_index] = fill_data; m_rdy[fill_index] = 1;
    end
    if (acc) begin
      m_v[m_tail] = 1; m_cat[m_tail] = alloc_category; m_tag[m_tail] = alloc_tag;
      m_addr[m_tail] = '0; m_val[m_tail] = '0; m_rdy[m_tail] = 0; m_col[m_tail] = m_color;
      m_color = m_color + 1;
    end
    if (flush) for (int i = 0; i < N; i++) if (!(m_wait && i == h)) m_v[i] = 0;
    if (freed) m_v[h] = 0;
    if (flush) begin
      m_tail = m_wait ? (h + 1) % N : h;
      m_cnt = (m_wait && !mem_wr_ack) ? 1 : 0;
    end else begin
      if (acc) m_tail = (m_tail + 1) % N;
      m_cnt = m_cnt + int'(acc) - int'(freed);
    end
    if (freed) m_head = (h + 1) % N;
    m_wait = go || (m_wait && !mem_wr_ack);
    m_err = err;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", lsq_count, m_cnt);
      check("tail", lsq_tail, m_tail);
      check("alloc_ready", alloc_ready, m_cnt < N);
      check("mem_wr_req", mem_wr_req, m_wait);
      check("commit_error", commit_error, m_err);
      if (m_wait) begin
        check("mem_wr_addr", mem_wr_addr, m_waddr);
        check("mem_wr_data", mem_wr_data, m_wdata);
      end
      for (int i = 0; i < N; i++)
        check($sformatf("entry%0d", i), lsq_out[i],
              {m_v[i], m_cat[i], m_tag[i], m_addr[i], m_val[i], m_rdy[i], m_col[i]});
    end
  end

  task automatic idle();
    alloc_valid = 0; alloc_category = 0; alloc_tag = '0;
    upd_pointer = '0; upd_address = '0; upd_value = '0; upd_ready = 0;
    fill_valid = 0; fill_index = '0; fill_data = '0;
    commit_valid = 0; commit_tag = '0; flush = 0; mem_wr_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input bit cat, input logic [TW-1:0] tag);
    idle(); alloc_valid = 1; alloc_category = cat; alloc_tag = tag; tick();
  endtask

  task automatic commit(input logic [TW-1:0] tag);
    idle(); commit_valid = 1; commit_tag = tag; tick();
  endtask

  task automatic update(input int ptr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); upd_pointer = PW'(ptr); upd_address = a; upd_value = d; upd_ready = 1; tick();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #2 reset = 1; chk_en = 1;
    check("rst_count", lsq_count, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_req", mem_wr_req, 0);
    alloc(0, 5);
    alloc(1, 6);
    check("lit_count2", lsq_count, 2);
    check("lit_tail2", lsq_tail, 2);
    check("lit_e0_tag", lsq_out[0][TH:TL], 5);
    check("lit_e1_color", lsq_out[1][31:0], 1);
    check("lit_e1_cat", lsq_out[1][CB], 1);
    commit(9);
    check("lit_err_hi", commit_error, 1);
    idle(); tick();
    check("lit_err_lo", commit_error, 0);
    check("lit_err_count", lsq_count, 2);
    alloc(0, 7);
    idle();
    upd_pointer = 3; upd_address = 64'h300; upd_value = 64'h11; upd_ready = 0;
    fill_valid = 1; fill_index = 2; fill_data = 64'h22;
    tick();
    check("lit_uf_addr", lsq_out[2][AH:AL], 64'h300);
    check("lit_uf_value", lsq_out[2][DH:DL], 64'h22);
    check("lit_uf_ready", lsq_out[2][RB], 1);
    commit(5);
    check("lit_load_commit", lsq_count, 2);
    update(2, 64'h100, 64'hDEAD);
    commit(6);
    for (int k = 0; k < 3; k++) begin
      idle(); tick();
      check("lit_req_held", mem_wr_req, 1);
      check("lit_req_addr", mem_wr_addr, 64'h100);
      check("lit_req_data", mem_wr_data, 64'hDEAD);
    end
    idle(); mem_wr_ack = 1; tick();
    check("lit_ack_req", mem_wr_req, 0);
    check("lit_ack_count", lsq_count, 1);
    for (int k = 0; k < 15; k++) alloc(0, TW'(100 + k));
    check("lit_full_ready", alloc_ready, 0);
    check("lit_full_tail", lsq_tail, 2);
    alloc(0, 99);
    check("lit_17th_count", lsq_count, 16);
    idle(); commit_valid = 1; commit_tag = 7; alloc_valid = 1; alloc_tag = 98; tick();
    check("lit_full_commit", lsq_count, 15);
    idle(); commit_valid = 1; commit_tag = 100; alloc_valid = 1; alloc_tag = 200; tick();
    check("lit_swap_count", lsq_count, 15);
    check("lit_swap_tail", lsq_tail, 3);
    idle(); flush = 1; tick();
    check("lit_flush_count", lsq_count, 0);
    check("lit_flush_tail", lsq_tail, 4);
    alloc(1, 50); alloc(0, 51); alloc(0, 52); alloc(0, 53);
    update(5, 64'h500, 64'h55);
    commit(50);
    idle(); flush = 1; tick();
    check("lit_wflush_count", lsq_count, 1);
    check("lit_wflush_tail", lsq_tail, 5);
    check("lit_wflush_req", mem_wr_req, 1);
    idle(); mem_wr_ack = 1; tick();
    check("lit_wflush_done", lsq_count, 0);
    for (int c = 0; c < 1500; c++) begin
      idle();
      alloc_valid = $urandom_range(0, 1) == 1;
      alloc_category = 1'($urandom_range(0, 1));
      alloc_tag = TW'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) begin
        upd_pointer = PW'($urandom_range(0, N + 1));
        upd_address = {$urandom, $urandom};
        upd_value = {$urandom, $urandom};
        upd_ready = 1'($urandom_range(0, 1));
      end
      fill_valid = $urandom_range(0, 4) == 0;
      fill_index = (PW-1)'($urandom_range(0, N - 1));
      fill_data = {$urandom, $urandom};
      if (!m_wait && $urandom_range(0, 2) == 0) begin
        commit_valid = 1;
        commit_tag = $urandom_range(0, 3) != 0 ? m_tag[m_head] : TW'($urandom_range(0, 63));
      end
      flush = $urandom_range(0, 39) == 0;
      mem_wr_ack = m_wait && $urandom_range(0, 2) == 0;
      tick();
    end
    idle(); mem_wr_ack = 1; tick();
    idle(); flush = 1; tick();
    alloc(1, 77);
    commit(77);
    check("lit_pre_reset_req", mem_wr_req, 1);
    #2 reset = 0;
    #1;
    check("lit_async_req", mem_wr_req, 0);
    check("lit_async_count", lsq_count, 0);
    check("lit_async_valid", lsq_out[m_head][VB], 0);
    @(posedge clk);
    #2 reset = 1;
    idle();
    repeat (3) tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
